// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search block.
package sar_pkg;
   localparam int SAR_WIDTH = 4;
   localparam int MAX_STEPS = SAR_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE, S_ERR} state_t;
endpackage

// File: rtl/sar_bounds.sv
// Search window registers lo/hi with midpoint probe and empty-range lookahead; no control state.
module sar_bounds #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init_i,
   input  logic             gt_i,
   input  logic             lt_i,
   output logic [WIDTH-1:0] probe_o,
   output logic             gt_empty_o,
   output logic             lt_empty_o
);
   logic [WIDTH:0] lo_q, hi_q, lo_d, hi_d;
   logic [WIDTH:0] probe_x;

   assign probe_o = WIDTH'((lo_q + hi_q) >> 1);
   assign probe_x = {1'b0, probe_o};

   // Compare without forming probe-1, so a probe of 0 never wraps the window.
   assign gt_empty_o = (probe_x + (WIDTH+1)'(1)) > hi_q;
   assign lt_empty_o = (lo_q + (WIDTH+1)'(1)) > probe_x;

   always_comb begin
      lo_d = lo_q;
      hi_d = hi_q;
      if (init_i) begin
         lo_d = '0;
         hi_d = {1'b0, {WIDTH{1'b1}}};
      end else if (gt_i) begin
         lo_d = probe_x + (WIDTH+1)'(1);
      end else if (lt_i) begin
         hi_d = probe_x - (WIDTH+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lo_q <= '0;
         hi_q <= '0;
      end else begin
         lo_q <= lo_d;
         hi_q <= hi_d;
      end
   end
endmodule

// File: rtl/sar_search_4.sv
// Binary search of a hidden value through an external 3-way comparator; one probe per accepted compare.
// Optional SAR_SEARCH_STEPCNT_EN adds a 'steps' output counting accepted comparisons.
module sar_search_4
   import sar_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] probe,
   output logic             probe_valid,
   input  logic             cmp_valid,
   input  logic             cmp_gt,
   input  logic             cmp_eq,
   input  logic             cmp_lt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
`ifdef SAR_SEARCH_STEPCNT_EN
   output logic [$clog2(WIDTH+2)-1:0] steps,
`endif
   output logic             error
);
   state_t           state_q;
   logic             probe_valid_q, busy_q, done_q, error_q;
   logic [WIDTH-1:0] result_q;
   logic             accept, onehot, init, upd_gt, upd_lt, gt_empty, lt_empty;

   assign accept = (state_q == S_PROBE) && probe_valid_q && cmp_valid;
   assign onehot = (cmp_gt ^ cmp_eq ^ cmp_lt) && !(cmp_gt && cmp_eq && cmp_lt);
   assign init   = (state_q == S_IDLE) && start;
   assign upd_gt = accept && onehot && cmp_gt;
   assign upd_lt = accept && onehot && cmp_lt;

   sar_bounds #(.WIDTH(WIDTH)) u_bounds (
      .clk        (clk),
      .rst        (rst),
      .init_i     (init),
      .gt_i       (upd_gt),
      .lt_i       (upd_lt),
      .probe_o    (probe),
      .gt_empty_o (gt_empty),
      .lt_empty_o (lt_empty)
   );

   // probe_valid trails entry into PROBE by one cycle so the first probe settles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         probe_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         result_q      <= '0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q       <= S_PROBE;
                  busy_q        <= 1'b1;
                  probe_valid_q <= 1'b0;
               end
            end
            S_PROBE: begin
               probe_valid_q <= 1'b1;
               if (accept) begin
                  if (!onehot || (cmp_gt && gt_empty) || (cmp_lt && lt_empty)) begin
                     state_q       <= S_ERR;
                     error_q       <= 1'b1;
                     busy_q        <= 1'b0;
                     probe_valid_q <= 1'b0;
                  end else if (cmp_eq) begin
                     state_q       <= S_DONE;
                     done_q        <= 1'b1;
                     busy_q        <= 1'b0;
                     probe_valid_q <= 1'b0;
                     result_q      <= probe;
                  end
               end
            end
            S_DONE:  state_q <= S_IDLE;
            S_ERR:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef SAR_SEARCH_STEPCNT_EN
   logic [$clog2(WIDTH+2)-1:0] steps_q;

   always_ff @(posedge clk) begin
      if (rst || init) begin
         steps_q <= '0;
      end else if (accept && (int'(steps_q) < MAX_STEPS)) begin
         steps_q <= steps_q + 1'b1;
      end
   end

   assign steps = steps_q;
`endif

   assign probe_valid = probe_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;
   assign result      = result_q;
endmodule

// File: tb/tb_sar_search_4.sv
// Scoreboard bench: directed searches push expected probes/outcomes, a negedge monitor pops and compares.
module tb_sar_search_4;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] probe, result;
   logic       probe_valid, cmp_valid, cmp_gt, cmp_eq, cmp_lt, busy, done, error;
`ifdef SAR_SEARCH_STEPCNT_EN
   logic [2:0] steps;
`endif

   logic [3:0] tgt = 4'd0;
   int         mode = 0;    // 0: honest comparator, 1: gt and eq both set, 2: always lt
   int         waitn = 0;
   int         wcnt = 0;
   int         cyc = 0;
   int         start_cyc = 0;
   int         checks = 0;
   int         failures = 0;

   typedef struct packed {
      logic        is_err;
      logic [3:0]  res;
      logic [31:0] st;
      logic [31:0] lat;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] probe_q[$];

   logic       prev_pv = 1'b0, prev_acc = 1'b0;
   logic [3:0] prev_probe = 4'd0;

   sar_search_4 dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .probe       (probe),
      .probe_valid (probe_valid),
      .cmp_valid   (cmp_valid),
      .cmp_gt      (cmp_gt),
      .cmp_eq      (cmp_eq),
      .cmp_lt      (cmp_lt),
      .busy        (busy),
      .done        (done),
      .result      (result),
`ifdef SAR_SEARCH_STEPCNT_EN
      .steps       (steps),
`endif
      .error       (error)
   );

   always #5 clk = ~clk;

   // comparator_4 behaviour with A=tgt, B=probe, plus fault modes
   assign cmp_gt    = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (tgt > probe);
   assign cmp_eq    = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (tgt == probe);
   assign cmp_lt    = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (tgt < probe);
   assign cmp_valid = probe_valid && (wcnt >= waitn);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!probe_valid || cmp_valid) wcnt <= 0;
      else                           wcnt <= wcnt + 1;
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_pv  = 1'b0;
         prev_acc = 1'b0;
      end else begin
         if (probe_valid && prev_pv && !prev_acc)
            chk("probe_stable", probe, prev_probe);
         if (probe_valid && cmp_valid) begin
            if (probe_q.size() == 0) chk("unexpected_probe", probe, 16);
            else chk("probe_seq", probe, probe_q.pop_front());
         end
         if (done || error) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_end", {done, error}, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("end_kind_err", error, e.is_err);
               chk("end_kind_done", done, !e.is_err);
               chk("result", result, e.res);
               chk("latency", cyc - start_cyc, e.lat);
               chk("busy_at_end", busy, 0);
`ifdef SAR_SEARCH_STEPCNT_EN
               chk("steps", steps, e.st);
`endif
            end
         end
         prev_pv    = probe_valid;
         prev_acc   = probe_valid && cmp_valid;
         prev_probe = probe;
      end
   end

   task automatic do_start(input logic [3:0] t, input int m, input int w);
      @(negedge clk);
      tgt = t; mode = m; waitn = w;
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end();
      bit seen;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         if (done || error) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) chk("end_timeout", 0, 1);
   endtask

   task automatic push(input logic is_err, input logic [3:0] res, input int st,
                       input int lat, input logic [19:0] pr, input int n);
      exp_t e;
      e.is_err = is_err; e.res = res; e.st = st; e.lat = lat;
      exp_q.push_back(e);
      for (int i = 0; i < n; i++) probe_q.push_back(pr[4*i +: 4]);
   endtask

   task automatic search(input logic [3:0] t, input int m, input int w, input logic is_err,
                         input logic [3:0] res, input int st, input int lat,
                         input logic [19:0] pr, input int n);
      push(is_err, res, st, lat, pr, n);
      do_start(t, m, w);
      wait_end();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_probe", probe, 0);
      chk("rst_probe_valid", probe_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_result", result, 0);
      rst = 1'b0;
      @(negedge clk);

      search(4'd7,  0, 0, 1'b0, 4'd7,  1, 3,  20'h00007, 1);
      search(4'd0,  0, 0, 1'b0, 4'd0,  4, 6,  20'h00137, 4);
      search(4'd15, 0, 0, 1'b0, 4'd15, 5, 7,  20'hFEDB7, 5);
      search(4'd9,  0, 3, 1'b0, 4'd9,  3, 14, 20'h009B7, 3);
      search(4'd9,  1, 0, 1'b1, 4'd9,  1, 3,  20'h00007, 1);
      search(4'd9,  2, 0, 1'b1, 4'd9,  4, 6,  20'h00137, 4);

      // reset during the second probe of a search for 10
      probe_q.push_back(4'd7);
      probe_q.push_back(4'd11);
      do_start(4'd10, 0, 0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("midrst_probe", probe, 0);
      chk("midrst_probe_valid", probe_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_error", error, 0);
      chk("midrst_result", result, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      search(4'd5, 0, 0, 1'b0, 4'd5, 3, 5, 20'h00537, 3);

      // start pulses while busy and in the DONE cycle must be ignored
      push(1'b0, 4'd6, 4, 6, 20'h06537, 4);
      do_start(4'd6, 0, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_end();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ign_done_busy", busy, 0);
      repeat (3) @(negedge clk);
      chk("ign_done_idle_busy", busy, 0);

      // start in the ERR cycle is ignored
      search(4'd6, 2, 0, 1'b1, 4'd6, 4, 6, 20'h00137, 4);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ign_err_busy", busy, 0);
      repeat (3) @(negedge clk);
      chk("ign_err_idle_busy", busy, 0);
      chk("ign_err_result", result, 6);

      // back to back: start in the cycle right after DONE
      search(4'd3,  0, 0, 1'b0, 4'd3,  2, 4, 20'h00037, 2);
      search(4'd12, 0, 0, 1'b0, 4'd12, 4, 6, 20'h0CDB7, 4);

      repeat (4) @(negedge clk);
      chk("exp_queue_empty", exp_q.size(), 0);
      chk("probe_queue_empty", probe_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d required=0", cyc);
      $fatal(1, "timeout");
   end
endmodule
